mmix_logic_shift_unit: RTL and testbench
========================================

# mmix_logic_shift_unit

Parametrised successor to the MMIX single-cycle logic ALU. It executes the eight MMIX bitwise operations plus the four shift operations (SL, SLU, SR, SRU) on W-bit operands. Shifts run as a multi-cycle iterative shifter, STEP bits per cycle. It sits beside the existing ALU in the execute stage, collects the Y and Z operands through independent valid strobes, and returns a single register write-back with a done pulse and an overflow flag.

## Interface
- W, 64, operand/result width (power of two, ≥8)
- STEP, 8, maximum shift distance per EXEC cycle (1 ≤ STEP ≤ W)
- RA_W, 8, register address width

- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- enable  in  1  start request; sampled only in IDLE
- op  in  4  operation: 0 AND, 1 OR, 2 XOR, 3 ANDN, 4 ORN, 5 NAND, 6 NOR, 7 NXOR, 8 SL, 9 SLU, 10 SR, 11 SRU, 12–15 illegal
- dst  in  RA_W  destination register; latched with op
- y, z  in  W  operands
- y_valid, z_valid  in  1  operand-valid levels
- busy  out  1  high in any state other than IDLE
- regwe  out  1  one-cycle write-enable pulse
- regwa  out  RA_W  write address; valid with regwe
- regwd  out  W  write data; valid with regwe
- cf  out  1  overflow flag; updated at each done and held until the next done
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, WAIT, EXEC, DONE. Reset returns to IDLE. Reset clears all outputs, both operand registers, both captured flags, and the remaining-shift count to 0.
- IDLE:
  - enable=1 latches op and dst, clears the captured flags, and moves to WAIT.
  - enable=0 stays in IDLE.
- WAIT:
  - Each cycle, y is captured when y_valid=1 and z is captured when z_valid=1, independently. Each sets its captured flag. A later valid before both are captured overwrites that operand.
  - When both flags are set at a clock edge (including both setting on the same edge), move to EXEC.
- EXEC, logic ops (0–7):
  - One cycle. Computes AND y&z; OR y|z; XOR y^z; ANDN y&~z; ORN y|~z; NAND ~(y&z); NOR ~(y|z); NXOR ~(y^z).
  - cf=0. Move to DONE.
- EXEC, shifts (8–11):
  - On entry, n = min(z, W), treating z as unsigned, so n saturates to W. The accumulator is loaded with y.
  - Each cycle shifts the accumulator by s = min(STEP, remaining) and decrements remaining by s.
  - SL and SLU shift left with zero fill. SR shifts right with sign fill. SRU shifts right with zero fill.
  - n=0 still costs one EXEC cycle, and the result equals y.
  - After the last step, move to DONE. EXEC length k = max(1, ceil(n/STEP)).
  - SL overflow: cf=1 iff the final result, arithmetically shifted right by n, differs from y. For n=W this means cf=1 iff y≠0. SLU, SR and SRU give cf=0.
- Illegal op: one EXEC cycle, then DONE with regwe=0 and cf=0. done still pulses.
- DONE:
  - done=1. regwe=1 for legal ops. regwa=dst and regwd=result are driven from registers.
  - Next state is IDLE unconditionally. enable is not sampled in DONE.
- regwd and regwa hold their last values after DONE. regwe and done are 0 outside DONE.
- A reset asserted in any state aborts the operation: no regwe or done is produced, and the unit is in IDLE on the next cycle.

## Timing
- Cycle numbering: enable sampled in cycle 0, WAIT from cycle 1. If both valids are high in cycle 1, EXEC starts in cycle 2 and DONE is in cycle 2+k.
- Logic op with operands ready: done in cycle 3.
- Each extra WAIT cycle adds one cycle of latency.
- Minimum issue interval: DONE → IDLE → new enable. Back-to-back operations start every k+3 cycles at best.
- Operands present before WAIT are not captured. The valids must be high during WAIT.

## Test plan
- ORN, W=64: enable with op=4 in cycle 0, y=3 with y_valid from cycle 1, z=5 with z_valid from cycle 2 → done, regwe and regwd=0xFFFF_FFFF_FFFF_FFFB in cycle 4, cf=0, regwa=dst.
- Back-to-back XOR then AND, y=3, z=5, valids held high → regwd=6 then regwd=1. The done pulses are 4 cycles apart. busy drops for exactly one cycle between them.
- SL, W=64, STEP=8: y=1, z=63 → k=8, done in cycle 10, regwd=0x8000_0000_0000_0000, cf=1. Repeat as SLU → same regwd, cf=0.
- SR with y=0x8000_0000_0000_0000, z=70 → n saturates to 64, k=8, regwd=all ones, cf=0. SRU with the same operands → regwd=0. Shift with z=0 → k=1, regwd=y.
- Illegal op=15 with operands valid → done pulse in cycle 3, regwe=0, cf=0. busy returns to 0 in cycle 4.
- reset_n=0 during the fourth EXEC cycle of an SL with z=63 → no regwe or done afterwards. All outputs read 0 and the unit is in IDLE the following cycle. A fresh ORN then completes normally.

Source files
------------

// File: rtl/mmix_logic_shift_unit.sv
// MMIX bitwise logic and iterative shift unit: collects Y/Z through independent
// valid strobes, executes one op (shifts take STEP bits per cycle), writes back once.
module mmix_logic_shift_unit #(
  parameter int W    = 64,
  parameter int STEP = 8,
  parameter int RA_W = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  input  logic [3:0]      op,
  input  logic [RA_W-1:0] dst,
  input  logic [W-1:0]    y,
  input  logic [W-1:0]    z,
  input  logic            y_valid,
  input  logic            z_valid,
  output logic            busy,
  output logic            regwe,
  output logic [RA_W-1:0] regwa,
  output logic [W-1:0]    regwd,
  output logic            cf,
  output logic            done
);

  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] W_CNT    = CW'(W);
  localparam logic [CW-1:0] STEP_CNT = CW'(STEP);
  localparam logic [W-1:0]  W_OPND   = W'(W);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EXEC, S_DONE} state_t;

  state_t            state_reg, state_next;
  logic [3:0]        op_reg;
  logic [RA_W-1:0]   dst_reg;
  logic [W-1:0]      y_reg, z_reg, acc_reg;
  logic              y_got_reg, z_got_reg;
  logic [CW-1:0]     rem_reg, n_reg;
  logic              regwe_reg, cf_reg, done_reg;
  logic [RA_W-1:0]   regwa_reg;
  logic [W-1:0]      regwd_reg;

  logic [W-1:0]        y_next, z_next, acc_shift, logic_res, result;
  logic                y_got_next, z_got_next, both_ready;
  logic                is_logic, is_shift, exec_last, sl_ovf;
  logic [CW-1:0]       n_calc, step_amt, rem_after;
  logic signed [W-1:0] sra_back;

  assign busy  = (state_reg != S_IDLE);
  assign regwe = regwe_reg;
  assign regwa = regwa_reg;
  assign regwd = regwd_reg;
  assign cf    = cf_reg;
  assign done  = done_reg;

  always_comb begin
    y_next     = y_reg;
    z_next     = z_reg;
    y_got_next = y_got_reg;
    z_got_next = z_got_reg;
    if (state_reg == S_WAIT) begin
      if (y_valid) begin
        y_next     = y;
        y_got_next = 1'b1;
      end
      if (z_valid) begin
        z_next     = z;
        z_got_next = 1'b1;
      end
    end
    both_ready = y_got_next & z_got_next;
    // z is unsigned; anything at or beyond W saturates the shift distance to W
    n_calc     = (z_next >= W_OPND) ? W_CNT : z_next[CW-1:0];
  end

  always_comb begin
    is_logic  = ~op_reg[3];
    is_shift  = op_reg[3] & ~op_reg[2];
    step_amt  = (rem_reg > STEP_CNT) ? STEP_CNT : rem_reg;
    rem_after = rem_reg - step_amt;
    acc_shift = acc_reg;
    case (op_reg[1:0])
      2'd0, 2'd1: acc_shift = acc_reg << step_amt;
      2'd2:       acc_shift = $signed(acc_reg) >>> step_amt;
      default:    acc_shift = acc_reg >> step_amt;
    endcase
    logic_res = '0;
    case (op_reg[2:0])
      3'd0:    logic_res = y_reg & z_reg;
      3'd1:    logic_res = y_reg | z_reg;
      3'd2:    logic_res = y_reg ^ z_reg;
      3'd3:    logic_res = y_reg & ~z_reg;
      3'd4:    logic_res = y_reg | ~z_reg;
      3'd5:    logic_res = ~(y_reg & z_reg);
      3'd6:    logic_res = ~(y_reg | z_reg);
      default: logic_res = ~(y_reg ^ z_reg);
    endcase
    result    = is_shift ? acc_shift : logic_res;
    exec_last = !is_shift || (rem_after == '0);
    // SL overflows when shifting the result back arithmetically does not recover y
    sra_back  = $signed(acc_shift) >>> n_reg;
    sl_ovf    = (sra_back != $signed(y_reg));
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (enable) state_next = S_WAIT;
      S_WAIT:  if (both_ready) state_next = S_EXEC;
      S_EXEC:  if (exec_last) state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
      op_reg    <= '0;
      dst_reg   <= '0;
      y_reg     <= '0;
      z_reg     <= '0;
      acc_reg   <= '0;
      y_got_reg <= 1'b0;
      z_got_reg <= 1'b0;
      rem_reg   <= '0;
      n_reg     <= '0;
      regwe_reg <= 1'b0;
      regwa_reg <= '0;
      regwd_reg <= '0;
      cf_reg    <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      regwe_reg <= 1'b0;
      done_reg  <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (enable) begin
            op_reg    <= op;
            dst_reg   <= dst;
            y_got_reg <= 1'b0;
            z_got_reg <= 1'b0;
          end
        end
        S_WAIT: begin
          y_reg     <= y_next;
          z_reg     <= z_next;
          y_got_reg <= y_got_next;
          z_got_reg <= z_got_next;
          if (both_ready) begin
            acc_reg <= y_next;
            rem_reg <= n_calc;
            n_reg   <= n_calc;
          end
        end
        S_EXEC: begin
          acc_reg <= acc_shift;
          rem_reg <= rem_after;
          if (exec_last) begin
            done_reg <= 1'b1;
            cf_reg   <= is_shift && (op_reg[1:0] == 2'd0) && sl_ovf;
            if (is_logic || is_shift) begin
              regwe_reg <= 1'b1;
              regwa_reg <= dst_reg;
              regwd_reg <= result;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mmix_logic_shift_unit.sv
// Directed bench for mmix_logic_shift_unit (W=64, STEP=8, RA_W=8); cycle 0 is the
// cycle enable is presented, outputs are sampled 1 time unit after each rising edge.
module tb_mmix_logic_shift_unit;

  logic        clk = 1'b0;
  logic        reset_n, enable, y_valid, z_valid;
  logic [3:0]  op;
  logic [7:0]  dst;
  logic [63:0] y, z;
  logic        busy, regwe, cf, done;
  logic [7:0]  regwa;
  logic [63:0] regwd;

  int n_checks = 0;
  int n_fail   = 0;

  mmix_logic_shift_unit #(.W(64), .STEP(8), .RA_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .op(op), .dst(dst),
    .y(y), .z(z), .y_valid(y_valid), .z_valid(z_valid),
    .busy(busy), .regwe(regwe), .regwa(regwa), .regwd(regwd), .cf(cf), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one op from IDLE and returns the cycle in which done was seen (-1 on timeout)
  task automatic run_op(input logic [3:0] o, input logic [7:0] d, input logic [63:0] yv,
                        input logic [63:0] zv, input int ydel, input int zdel,
                        output int cyc, output logic we, output logic [7:0] wa,
                        output logic [63:0] wd, output logic cfo);
    enable = 1'b1; op = o; dst = d; y = yv; z = zv; y_valid = 1'b0; z_valid = 1'b0;
    we = 1'b0; wa = '0; wd = '0; cfo = 1'b0;
    step();
    cyc = 1;
    enable = 1'b0;
    while (cyc < 100) begin
      y_valid = (cyc >= ydel);
      z_valid = (cyc >= zdel);
      step();
      cyc++;
      if (done) begin
        we = regwe; wa = regwa; wd = regwd; cfo = cf;
        y_valid = 1'b0; z_valid = 1'b0;
        $display("op=%0d y=%h z=%h -> done cycle %0d regwe=%0d regwa=%0d regwd=%h cf=%0d",
                 o, yv, zv, cyc, we, wa, wd, cfo);
        return;
      end
    end
    cyc = -1;
    y_valid = 1'b0; z_valid = 1'b0;
    $display("op=%0d y=%h z=%h -> no done within budget", o, yv, zv);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; op = '0; dst = '0; y = '0; z = '0;
    y_valid = 1'b0; z_valid = 1'b0;
    step(); step();
    n_checks += 6;
    if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %0d want 0", busy); end
    if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %0d want 0", done); end
    if (regwe !== 1'b0) begin n_fail++; $display("FAIL reset_regwe: got %0d want 0", regwe); end
    if (regwa !== 8'h0) begin n_fail++; $display("FAIL reset_regwa: got %h want 0", regwa); end
    if (regwd !== 64'h0) begin n_fail++; $display("FAIL reset_regwd: got %h want 0", regwd); end
    if (cf !== 1'b0)    begin n_fail++; $display("FAIL reset_cf: got %0d want 0", cf); end
    reset_n = 1'b1;
    step();
    $display("reset: busy=%0d done=%0d regwe=%0d", busy, done, regwe);
  endtask

  task automatic test_orn();
    int cyc; logic we, c; logic [7:0] wa; logic [63:0] wd;
    run_op(4'd4, 8'd17, 64'd3, 64'd5, 1, 2, cyc, we, wa, wd, c);
    n_checks += 5;
    if (cyc !== 4)  begin n_fail++; $display("FAIL orn_cycle: got %0d want 4", cyc); end
    if (we !== 1'b1) begin n_fail++; $display("FAIL orn_regwe: got %0d want 1", we); end
    if (wd !== 64'hFFFF_FFFF_FFFF_FFFB) begin n_fail++; $display("FAIL orn_regwd: got %h want fffffffffffffffb", wd); end
    if (c !== 1'b0)  begin n_fail++; $display("FAIL orn_cf: got %0d want 0", c); end
    if (wa !== 8'd17) begin n_fail++; $display("FAIL orn_regwa: got %0d want 17", wa); end
    step();
  endtask

  task automatic test_back_to_back();
    int cyc1, cyc2; logic we, c; logic [7:0] wa; logic [63:0] wd;
    logic b_done, b_gap, b_after;
    run_op(4'd2, 8'd5, 64'd3, 64'd5, 1, 1, cyc1, we, wa, wd, c);
    n_checks += 2;
    if (wd !== 64'd6) begin n_fail++; $display("FAIL b2b_xor_regwd: got %h want 6", wd); end
    if (cyc1 !== 3)   begin n_fail++; $display("FAIL b2b_xor_cycle: got %0d want 3", cyc1); end
    b_done = busy;
    step();
    b_gap = busy;
    run_op(4'd0, 8'd6, 64'd3, 64'd5, 1, 1, cyc2, we, wa, wd, c);
    b_after = busy;
    n_checks += 5;
    if (wd !== 64'd1)    begin n_fail++; $display("FAIL b2b_and_regwd: got %h want 1", wd); end
    if (cyc2 + 1 !== 4)  begin n_fail++; $display("FAIL b2b_done_spacing: got %0d want 4", cyc2 + 1); end
    if (b_done !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_in_done: got %0d want 1", b_done); end
    if (b_gap !== 1'b0)  begin n_fail++; $display("FAIL b2b_busy_gap: got %0d want 0", b_gap); end
    if (b_after !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_second: got %0d want 1", b_after); end
    step();
  endtask

  task automatic test_shift_left();
    int cyc; logic we, c; logic [7:0] wa; logic [63:0] wd;
    run_op(4'd9, 8'd2, 64'd1, 64'd63, 1, 1, cyc, we, wa, wd, c);
    n_checks += 3;
    if (cyc !== 10) begin n_fail++; $display("FAIL slu_cycle: got %0d want 10", cyc); end
    if (wd !== 64'h8000_0000_0000_0000) begin n_fail++; $display("FAIL slu_regwd: got %h want 8000000000000000", wd); end
    if (c !== 1'b0) begin n_fail++; $display("FAIL slu_cf: got %0d want 0", c); end
    step();
    run_op(4'd8, 8'd3, 64'd3, 64'd4, 1, 1, cyc, we, wa, wd, c);
    n_checks += 3;
    if (cyc !== 3)     begin n_fail++; $display("FAIL sl_short_cycle: got %0d want 3", cyc); end
    if (wd !== 64'h30) begin n_fail++; $display("FAIL sl_short_regwd: got %h want 30", wd); end
    if (c !== 1'b0)    begin n_fail++; $display("FAIL sl_short_cf: got %0d want 0", c); end
    step();
    run_op(4'd8, 8'd1, 64'd1, 64'd63, 1, 1, cyc, we, wa, wd, c);
    n_checks += 4;
    if (cyc !== 10) begin n_fail++; $display("FAIL sl_cycle: got %0d want 10", cyc); end
    if (wd !== 64'h8000_0000_0000_0000) begin n_fail++; $display("FAIL sl_regwd: got %h want 8000000000000000", wd); end
    if (c !== 1'b1) begin n_fail++; $display("FAIL sl_cf: got %0d want 1", c); end
    if (we !== 1'b1) begin n_fail++; $display("FAIL sl_regwe: got %0d want 1", we); end
    step();
  endtask

  task automatic test_illegal();
    int cyc; logic we, c; logic [7:0] wa; logic [63:0] wd;
    run_op(4'd15, 8'd9, 64'd3, 64'd5, 1, 1, cyc, we, wa, wd, c);
    n_checks += 4;
    if (cyc !== 3)   begin n_fail++; $display("FAIL illegal_cycle: got %0d want 3", cyc); end
    if (we !== 1'b0) begin n_fail++; $display("FAIL illegal_regwe: got %0d want 0", we); end
    if (c !== 1'b0)  begin n_fail++; $display("FAIL illegal_cf: got %0d want 0", c); end
    if (wd !== 64'h8000_0000_0000_0000) begin n_fail++; $display("FAIL illegal_regwd_hold: got %h want 8000000000000000", wd); end
    step();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL illegal_busy_after: got %0d want 0", busy); end
  endtask

  task automatic test_shift_right();
    int cyc; logic we, c; logic [7:0] wa; logic [63:0] wd;
    run_op(4'd10, 8'd4, 64'h8000_0000_0000_0000, 64'd70, 1, 1, cyc, we, wa, wd, c);
    n_checks += 3;
    if (cyc !== 10) begin n_fail++; $display("FAIL sr_sat_cycle: got %0d want 10", cyc); end
    if (wd !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL sr_sat_regwd: got %h want ffffffffffffffff", wd); end
    if (c !== 1'b0) begin n_fail++; $display("FAIL sr_sat_cf: got %0d want 0", c); end
    step();
    run_op(4'd11, 8'd4, 64'h8000_0000_0000_0000, 64'd70, 1, 1, cyc, we, wa, wd, c);
    n_checks += 2;
    if (cyc !== 10)  begin n_fail++; $display("FAIL sru_sat_cycle: got %0d want 10", cyc); end
    if (wd !== 64'h0) begin n_fail++; $display("FAIL sru_sat_regwd: got %h want 0", wd); end
    step();
    run_op(4'd10, 8'd7, 64'h8000_0000_0000_0100, 64'd12, 1, 1, cyc, we, wa, wd, c);
    n_checks += 2;
    if (cyc !== 4) begin n_fail++; $display("FAIL sr12_cycle: got %0d want 4", cyc); end
    if (wd !== 64'hFFF8_0000_0000_0000) begin n_fail++; $display("FAIL sr12_regwd: got %h want fff8000000000000", wd); end
    step();
    run_op(4'd11, 8'd8, 64'h0123_4567_89AB_CDEF, 64'd0, 1, 1, cyc, we, wa, wd, c);
    n_checks += 3;
    if (cyc !== 3) begin n_fail++; $display("FAIL zero_shift_cycle: got %0d want 3", cyc); end
    if (wd !== 64'h0123_4567_89AB_CDEF) begin n_fail++; $display("FAIL zero_shift_regwd: got %h want 0123456789abcdef", wd); end
    if (wa !== 8'd8) begin n_fail++; $display("FAIL zero_shift_regwa: got %0d want 8", wa); end
    step();
  endtask

  task automatic test_reset_abort();
    int cyc, seen; logic we, c; logic [7:0] wa; logic [63:0] wd;
    enable = 1'b1; op = 4'd8; dst = 8'd11; y = 64'd1; z = 64'd63;
    step();
    enable = 1'b0; y_valid = 1'b1; z_valid = 1'b1;
    step(); step(); step(); step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1; y_valid = 1'b0; z_valid = 1'b0;
    $display("abort: busy=%0d done=%0d regwe=%0d regwd=%h", busy, done, regwe, regwd);
    n_checks += 5;
    if (busy !== 1'b0)   begin n_fail++; $display("FAIL abort_busy: got %0d want 0", busy); end
    if (regwd !== 64'h0) begin n_fail++; $display("FAIL abort_regwd: got %h want 0", regwd); end
    if (regwa !== 8'h0)  begin n_fail++; $display("FAIL abort_regwa: got %h want 0", regwa); end
    if (cf !== 1'b0)     begin n_fail++; $display("FAIL abort_cf: got %0d want 0", cf); end
    if (done !== 1'b0 || regwe !== 1'b0) begin n_fail++; $display("FAIL abort_pulse: got done=%0d regwe=%0d want 0", done, regwe); end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done || regwe || busy) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL abort_quiet: got %0d active cycles want 0", seen); end
    run_op(4'd4, 8'd12, 64'd3, 64'd5, 1, 2, cyc, we, wa, wd, c);
    n_checks += 3;
    if (cyc !== 4) begin n_fail++; $display("FAIL abort_orn_cycle: got %0d want 4", cyc); end
    if (wd !== 64'hFFFF_FFFF_FFFF_FFFB) begin n_fail++; $display("FAIL abort_orn_regwd: got %h want fffffffffffffffb", wd); end
    if (wa !== 8'd12) begin n_fail++; $display("FAIL abort_orn_regwa: got %0d want 12", wa); end
    step();
  endtask

  initial begin
    test_reset();
    test_orn();
    test_back_to_back();
    test_shift_left();
    test_illegal();
    test_shift_right();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
